// File: rtl/elevator_pkg.sv
// Shared types and constants for the elevator request scheduler.
package elevator_pkg;

  typedef enum logic [1:0] {
    DIR_IDLE = 2'b00,
    DIR_UP   = 2'b01,
    DIR_DOWN = 2'b10
  } dir_t;

  localparam logic [2:0] GROUND = 3'b000;
  localparam logic [2:0] FLOOR1 = 3'b001;
  localparam logic [2:0] FLOOR2 = 3'b010;
  localparam logic [2:0] FLOOR3 = 3'b011;
  localparam logic [2:0] FLOOR4 = 3'b100;
  localparam logic [2:0] FLOOR5 = 3'b101;
  localparam logic [2:0] FLOOR6 = 3'b110;
  localparam logic [2:0] FLOOR7 = 3'b111;

  localparam int DEFAULT_NUM_FLOORS = 6;
  localparam int DEFAULT_FLOOR_W    = 3;

endpackage

// File: rtl/elevator_floor_search.sv
// Combinational finder: nearest or farthest set request bit strictly above
// or strictly below a reference floor.
module elevator_floor_search #(
  parameter int NUM_FLOORS = 6,
  parameter int FLOOR_W    = 3,
  parameter bit ABOVE      = 1'b1,
  parameter bit NEAREST    = 1'b1
) (
  input  logic [NUM_FLOORS-1:0] req_i,
  input  logic [FLOOR_W-1:0]    floor_i,
  output logic                  found_o,
  output logic [FLOOR_W-1:0]    floor_o
);

  // Scan order is picked so the last hit written is the one wanted.
  localparam bit ASCENDING = (ABOVE != NEAREST);

  function automatic logic hit(input int idx, input logic [FLOOR_W-1:0] ref_floor);
    return ABOVE ? (idx > int'(ref_floor)) : (idx < int'(ref_floor));
  endfunction

  always_comb begin
    found_o = 1'b0;
    floor_o = '0;
    if (ASCENDING) begin
      for (int i = 0; i < NUM_FLOORS; i++) begin
        if (req_i[i] && hit(i, floor_i)) begin
          found_o = 1'b1;
          floor_o = FLOOR_W'(i);
        end
      end
    end else begin
      for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
        if (req_i[i] && hit(i, floor_i)) begin
          found_o = 1'b1;
          floor_o = FLOOR_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/elevator_request_scheduler.sv
// Latches cabin/hall requests, keeps the SCAN travel direction and presents
// a registered target floor to the elevator controller.
module elevator_request_scheduler
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = DEFAULT_NUM_FLOORS,
  parameter int FLOOR_W    = DEFAULT_FLOOR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] btn_num_in,
  input  logic [NUM_FLOORS-1:0] btn_up_out,
  input  logic [NUM_FLOORS-1:0] btn_down_out,
  input  logic [FLOOR_W-1:0]    current_floor,
  input  logic                  serve,
  output logic [FLOOR_W-1:0]    target_floor,
  output logic                  target_valid,
  output logic                  dir_up,
  output logic                  dir_down,
  output logic [NUM_FLOORS-1:0] cab_lamps,
  output logic [NUM_FLOORS-1:0] up_lamps,
  output logic [NUM_FLOORS-1:0] down_lamps
);

  localparam logic [NUM_FLOORS-1:0] UP_MASK   = {1'b0, {(NUM_FLOORS-1){1'b1}}};
  localparam logic [NUM_FLOORS-1:0] DOWN_MASK = {{(NUM_FLOORS-1){1'b1}}, 1'b0};

  dir_t                  dir_q, dir_d;
  logic                  armed_q;
  logic [NUM_FLOORS-1:0] num_prev_q, up_prev_q, down_prev_q;
  logic [NUM_FLOORS-1:0] cab_q, cab_d, up_q, up_d, down_q, down_d;
  logic [FLOOR_W-1:0]    tgt_q, tgt_d;
  logic                  tgt_valid_q, tgt_valid_d;

  logic                  floor_ok;
  logic [NUM_FLOORS-1:0] at_mask, above_mask, below_mask;
  logic [NUM_FLOORS-1:0] pend_q, pend_d;
  logic [NUM_FLOORS-1:0] clr_cab, clr_up, clr_down;
  logic [NUM_FLOORS-1:0] rise_num, rise_up, rise_down;
  logic                  above_d, below_d;

  logic                  up_near_found, up_far_found, dn_near_found, dn_far_found;
  logic [FLOOR_W-1:0]    up_near_floor, up_far_floor, dn_near_floor, dn_far_floor;

  assign floor_ok   = int'(current_floor) < NUM_FLOORS;
  assign at_mask    = floor_ok ? (NUM_FLOORS'(1) << current_floor) : '0;
  assign above_mask = ~((NUM_FLOORS'(2) << current_floor) - NUM_FLOORS'(1));
  assign below_mask = (NUM_FLOORS'(1) << current_floor) - NUM_FLOORS'(1);
  assign pend_q     = cab_q | up_q | down_q;

  // armed_q suppresses capture on the first cycle after reset so buttons
  // held through reset do not register as fresh presses.
  assign rise_num  = armed_q ? (btn_num_in & ~num_prev_q) : '0;
  assign rise_up   = armed_q ? (btn_up_out & ~up_prev_q & UP_MASK) : '0;
  assign rise_down = armed_q ? (btn_down_out & ~down_prev_q & DOWN_MASK) : '0;

  always_comb begin
    clr_cab  = '0;
    clr_up   = '0;
    clr_down = '0;
    if (serve && floor_ok) begin
      clr_cab = at_mask;
      case (dir_q)
        DIR_UP: begin
          clr_up = at_mask;
          if (!(|(pend_q & above_mask))) clr_down = at_mask;
        end
        DIR_DOWN: begin
          clr_down = at_mask;
          if (!(|(pend_q & below_mask))) clr_up = at_mask;
        end
        default: begin
          clr_up   = at_mask;
          clr_down = at_mask;
        end
      endcase
    end
  end

  // Clear is applied after capture so a same-floor press loses to serve.
  assign cab_d  = (cab_q | rise_num) & ~clr_cab;
  assign up_d   = (up_q | rise_up) & ~clr_up;
  assign down_d = (down_q | rise_down) & ~clr_down;
  assign pend_d = cab_d | up_d | down_d;

  assign above_d = |(pend_d & above_mask);
  assign below_d = |(pend_d & below_mask);

  always_comb begin
    dir_d = dir_q;
    if (floor_ok) begin
      case (dir_q)
        DIR_UP:   dir_d = above_d ? DIR_UP : (below_d ? DIR_DOWN : DIR_IDLE);
        DIR_DOWN: dir_d = below_d ? DIR_DOWN : (above_d ? DIR_UP : DIR_IDLE);
        default:  dir_d = above_d ? DIR_UP : (below_d ? DIR_DOWN : DIR_IDLE);
      endcase
    end
  end

  elevator_floor_search #(.NUM_FLOORS(NUM_FLOORS), .FLOOR_W(FLOOR_W), .ABOVE(1'b1), .NEAREST(1'b1))
    u_up_near (.req_i(cab_q | up_q), .floor_i(current_floor), .found_o(up_near_found), .floor_o(up_near_floor));
  elevator_floor_search #(.NUM_FLOORS(NUM_FLOORS), .FLOOR_W(FLOOR_W), .ABOVE(1'b1), .NEAREST(1'b0))
    u_up_far (.req_i(down_q), .floor_i(current_floor), .found_o(up_far_found), .floor_o(up_far_floor));
  elevator_floor_search #(.NUM_FLOORS(NUM_FLOORS), .FLOOR_W(FLOOR_W), .ABOVE(1'b0), .NEAREST(1'b1))
    u_dn_near (.req_i(cab_q | down_q), .floor_i(current_floor), .found_o(dn_near_found), .floor_o(dn_near_floor));
  elevator_floor_search #(.NUM_FLOORS(NUM_FLOORS), .FLOOR_W(FLOOR_W), .ABOVE(1'b0), .NEAREST(1'b0))
    u_dn_far (.req_i(up_q), .floor_i(current_floor), .found_o(dn_far_found), .floor_o(dn_far_floor));

  always_comb begin
    tgt_d       = tgt_q;
    tgt_valid_d = tgt_valid_q;
    if (floor_ok) begin
      tgt_valid_d = |pend_q;
      case (dir_q)
        DIR_UP: begin
          if (up_near_found)     tgt_d = up_near_floor;
          else if (up_far_found) tgt_d = up_far_floor;
        end
        DIR_DOWN: begin
          if (dn_near_found)     tgt_d = dn_near_floor;
          else if (dn_far_found) tgt_d = dn_far_floor;
        end
        default: begin
          if (|(pend_q & at_mask)) tgt_d = current_floor;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dir_q       <= DIR_IDLE;
      armed_q     <= 1'b0;
      num_prev_q  <= '0;
      up_prev_q   <= '0;
      down_prev_q <= '0;
      cab_q       <= '0;
      up_q        <= '0;
      down_q      <= '0;
      tgt_q       <= FLOOR_W'(GROUND);
      tgt_valid_q <= 1'b0;
    end else begin
      dir_q       <= dir_d;
      armed_q     <= 1'b1;
      num_prev_q  <= btn_num_in;
      up_prev_q   <= btn_up_out;
      down_prev_q <= btn_down_out;
      cab_q       <= cab_d;
      up_q        <= up_d;
      down_q      <= down_d;
      tgt_q       <= tgt_d;
      tgt_valid_q <= tgt_valid_d;
    end
  end

  assign target_floor = tgt_q;
  assign target_valid = tgt_valid_q;
  assign dir_up       = (dir_q == DIR_UP);
  assign dir_down     = (dir_q == DIR_DOWN);
  assign cab_lamps    = cab_q;
  assign up_lamps     = up_q;
  assign down_lamps   = down_q;

endmodule

// File: doc/elevator_request_scheduler.md
Name: elevator_request_scheduler

Overview:
- Upstream stage of the elevator controller FSM.
- Latches cabin and hall button presses as per-floor pending requests and drives the request lamps.
- Keeps the travel direction (collective/SCAN policy) and presents one registered target floor.
- The controller compares its floor against target_floor to choose UP/DOWN/OPEN, and pulses serve when the door opens so the served requests are cleared.

Parameters:
- NUM_FLOORS, 6, number of served floors (2..8); floor 0 is ground.
- FLOOR_W, 3, floor index width; must satisfy 2**FLOOR_W >= NUM_FLOORS.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- btn_num_in  input  NUM_FLOORS  cabin floor buttons, level, synchronous to clk.
- btn_up_out  input  NUM_FLOORS  hall up-call buttons; bit NUM_FLOORS-1 is ignored.
- btn_down_out  input  NUM_FLOORS  hall down-call buttons; bit 0 is ignored.
- current_floor  input  FLOOR_W  floor the car is at or passing, from the controller.
- serve  input  1  one-cycle pulse: the door is opening at current_floor.
- target_floor  output  FLOOR_W  next floor to stop at.
- target_valid  output  1  at least one request is pending.
- dir_up  output  1  direction register is UP.
- dir_down  output  1  direction register is DOWN.
- cab_lamps  output  NUM_FLOORS  pending cabin requests.
- up_lamps  output  NUM_FLOORS  pending hall up requests.
- down_lamps  output  NUM_FLOORS  pending hall down requests.

Behaviour:
- Reset (async, reset=0): all lamps, btn_prev registers, target_floor and target_valid go to 0; direction goes to DIR_IDLE. Asserting reset mid-travel discards every pending request.
- Press capture:
  - Each button has a previous-value register. A request bit is set at the edge where btn=1 and prev=0, so the lamp is visible 1 cycle after the first high sample.
  - Holding a button never re-sets a bit after it is cleared.
  - up_lamps[NUM_FLOORS-1] and down_lamps[0] are constant 0.
- Serve clearing (serve=1 and current_floor < NUM_FLOORS), at floor f:
  - cab[f] is always cleared.
  - DIR_UP: clear up[f]. Also clear down[f] when no request of any kind remains above f.
  - DIR_DOWN: clear down[f]. Also clear up[f] when no request remains below f.
  - DIR_IDLE: clear both up[f] and down[f].
  - A press at floor f in the same cycle as the clear is discarded; clear wins. Presses at other floors are unaffected.
  - serve with current_floor >= NUM_FLOORS is ignored.
- Direction FSM (registered, evaluated every cycle on the post-update request vector):
  - DIR_IDLE -> DIR_UP if any request lies above current_floor; else -> DIR_DOWN if any lies below; else stay.
  - DIR_UP: stay while any request lies above. Else -> DIR_DOWN if any lies below. Else -> DIR_IDLE.
  - DIR_DOWN: symmetric to DIR_UP.
  - "Above"/"below" means strictly greater/less than current_floor, across cab|up|down.
- Target selection (registered; 1-cycle latency after a request or direction change):
  - DIR_UP: nearest floor above with cab|up set. If none, the highest floor above with down set.
  - DIR_DOWN: nearest floor below with cab|down set. If none, the lowest floor below with up set.
  - DIR_IDLE: current_floor if any bit is set there; otherwise target_floor holds its value.
  - target_valid = OR of all request bits (registered with target_floor).
  - No pending requests: target_valid=0 and target_floor holds its last value.
- current_floor >= NUM_FLOORS: the FSM and target hold; new presses are still captured.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package elevator_pkg holds:
  - dir_t (DIR_IDLE=2'b00, DIR_UP=2'b01, DIR_DOWN=2'b10);
  - floor constants GROUND..FLOOR7 (3'b000..3'b111);
  - default NUM_FLOORS / FLOOR_W.
- One natural sub-module: elevator_floor_search. It is a combinational, parameterised finder that returns the nearest/farthest set bit above or below a given floor plus a found flag, and is instantiated once per search.

Test Plan:
- Reset with buttons held high, release reset -> lamps stay 0, no request is latched until a fresh rising edge. target_valid=0, dir DIR_IDLE.
- current_floor=0, pulse btn_num_in[4] -> cab_lamps=6'b010000 the next cycle, then dir_up=1, target_floor=4, target_valid=1.
- Going up at floor 1 with cab[4] and down[3] pending -> target_floor=4. serve at 4 clears cab[4] -> dir_down=1, target_floor=3.
- At floor 2 in DIR_UP with up[2], down[2] and no requests above, serve -> both up[2] and down[2] clear. With no other requests -> DIR_IDLE, target_valid=0.
- btn_up_out[2] rising in the same cycle as serve at floor 2 -> up_lamps[2] stays 0. A simultaneous btn_num_in[5] rise -> cab_lamps[5]=1.
- Press btn_up_out[5] and btn_down_out[0] with NUM_FLOORS=6 -> lamps stay 0 and target_valid stays 0.
